// File: rtl/vga_text_engine_if.sv
// Register-port bundle between the bus bridge and the text engine:
// single-cycle write strobe, single-cycle read request, registered read data.
interface vga_text_engine_if #(
  parameter int C_AXI_ADDR_WIDTH = 13,
  parameter int C_AXI_DATA_WIDTH = 32
);
  // axil_wready_i / axil_rreq_i are one-cycle strobes with no back-pressure;
  // axil_rdata_o is valid the cycle after axil_rreq_i and holds until the next request.
  logic [C_AXI_DATA_WIDTH-1:0]   axil_wdata_i;
  logic [C_AXI_DATA_WIDTH/8-1:0] axil_wstrb_i;
  logic [C_AXI_ADDR_WIDTH-1:0]   axil_waddr_i;
  logic                          axil_wready_i;
  logic                          axil_rreq_i;
  logic [C_AXI_ADDR_WIDTH-1:0]   axil_raddr_i;
  logic [C_AXI_DATA_WIDTH-1:0]   axil_rdata_o;

  modport master (
    output axil_wdata_i, axil_wstrb_i, axil_waddr_i, axil_wready_i,
    output axil_rreq_i, axil_raddr_i,
    input  axil_rdata_o
  );

  modport slave (
    input  axil_wdata_i, axil_wstrb_i, axil_waddr_i, axil_wready_i,
    input  axil_rreq_i, axil_raddr_i,
    output axil_rdata_o
  );
endinterface

// File: rtl/vga_text_engine.sv
// Colour text-mode VGA engine: raster counters, 3-stage text/font/palette
// pipeline, blinking cursor, and a word-addressed register/RAM port.
module vga_text_engine #(
  parameter int H_ACTIVE         = 640,
  parameter int H_FP             = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BP             = 48,
  parameter int V_ACTIVE         = 480,
  parameter int V_FP             = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BP             = 33,
  parameter bit SYNC_POL         = 1'b0,
  parameter int FONT_H           = 16,
  parameter int BLINK_FRAMES     = 30,
  parameter int C_AXI_ADDR_WIDTH = 13,
  parameter int C_AXI_DATA_WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  vga_text_engine_if.slave    axil,
  output logic [7:0]          rgb_o,
  output logic                hsync_o,
  output logic                vsync_o,
  output logic                de_o
);

  localparam int COLS    = H_ACTIVE / 8;
  localparam int ROWS    = V_ACTIVE / FONT_H;
  localparam int CELLS   = COLS * ROWS;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB      = $clog2(FONT_H);
  localparam int DW      = C_AXI_DATA_WIDTH;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] CELLS_L  = 12'(CELLS);
  localparam logic [11:0] COLS_L   = 12'(COLS);
  localparam logic [3:0]  FROW_MSK = 4'(FONT_H - 1);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic        SYNC_ON  = SYNC_POL;

  // Storage: fixed 4096-deep arrays so 12-bit addresses index them directly.
  logic [7:0]  font_mem [4096];
  logic [15:0] text_mem [4096];
  logic [7:0]  palette  [16];

  logic [7:0]  cur_col, cur_row;
  logic [1:0]  ctrl;
  logic [11:0] h_cnt, v_cnt;
  logic [7:0]  frame_cnt;
  logic        blink_phase;

  logic [C_AXI_ADDR_WIDTH-1:0] waddr, raddr;
  logic [DW-1:0]               wdata, rd_val;
  logic [3:0]                  wstrb;
  logic                        unused_bits;

  assign waddr       = axil.axil_waddr_i;
  assign raddr       = axil.axil_raddr_i;
  assign wdata       = axil.axil_wdata_i;
  assign wstrb       = axil.axil_wstrb_i;
  assign unused_bits = ^{wdata[DW-1:16], wstrb[3:2]};

  logic wr_font, wr_text, wr_pal, wr_en;
  assign wr_en   = axil.axil_wready_i;
  assign wr_font = !waddr[12];
  assign wr_text = waddr[12] && (waddr[11:0] < CELLS_L);
  assign wr_pal  = (waddr[12:4] == 9'h1F1);

  // Raster counters and blink timebase
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt <= '0;
        if (frame_cnt == BLINK_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end else begin
        v_cnt <= v_cnt + 12'd1;
      end
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // S0: decode the raster position
  logic        act0, hs0, vs0;
  logic [7:0]  col0, row0;
  logic [3:0]  frow0;
  logic [2:0]  px0;
  logic [11:0] cell0;

  always_comb begin
    act0  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs0   = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_ON : ~SYNC_ON;
    vs0   = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_ON : ~SYNC_ON;
    col0  = h_cnt[10:3];
    row0  = 8'(v_cnt >> FB);
    frow0 = 4'(v_cnt) & FROW_MSK;
    px0   = h_cnt[2:0];
    cell0 = {4'b0, row0} * COLS_L + {4'b0, col0};
  end

  // RAMs: display reads are registered, so a same-cycle write is seen next time.
  logic [15:0] text_q;
  logic [7:0]  font_q;
  logic [3:0]  frow1;

  always_ff @(posedge clk_i) begin
    text_q <= text_mem[cell0];
    font_q <= font_mem[{text_q[7:0], frow1}];
    if (wr_en) begin
      if (wr_font && wstrb[0]) font_mem[waddr[11:0]] <= wdata[7:0];
      if (wr_text && wstrb[0]) text_mem[waddr[11:0]][7:0]  <= wdata[7:0];
      if (wr_text && wstrb[1]) text_mem[waddr[11:0]][15:8] <= wdata[15:8];
      if (wr_pal  && wstrb[0]) palette[waddr[3:0]] <= wdata[7:0];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cur_col <= '0;
      cur_row <= '0;
      ctrl    <= '0;
    end else if (wr_en && wstrb[0]) begin
      case (waddr)
        13'h1F00: cur_col <= wdata[7:0];
        13'h1F01: cur_row <= wdata[7:0];
        13'h1F02: ctrl    <= wdata[1:0];
        default: ;
      endcase
    end
  end

  // Register read port
  always_comb begin
    rd_val = '0;
    if (!raddr[12])                  rd_val = DW'(font_mem[raddr[11:0]]);
    else if (raddr[11:0] < CELLS_L)  rd_val = DW'(text_mem[raddr[11:0]]);
    else if (raddr[12:4] == 9'h1F1)  rd_val = DW'(palette[raddr[3:0]]);
    else if (raddr == 13'h1F00)      rd_val = DW'(cur_col);
    else if (raddr == 13'h1F01)      rd_val = DW'(cur_row);
    else if (raddr == 13'h1F02)      rd_val = DW'(ctrl);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)               axil.axil_rdata_o <= '0;
    else if (axil.axil_rreq_i) axil.axil_rdata_o <= rd_val;
  end

  // S1/S2 control pipeline travelling alongside the RAM reads
  logic       act1, hs1, vs1, act2, hs2, vs2;
  logic [7:0] col1, row1, col2, row2;
  logic [2:0] px1, px2;
  logic [3:0] fg2, bg2;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      act1 <= 1'b0;  hs1 <= ~SYNC_ON;  vs1 <= ~SYNC_ON;
      act2 <= 1'b0;  hs2 <= ~SYNC_ON;  vs2 <= ~SYNC_ON;
      col1 <= '0;  row1 <= '0;  px1 <= '0;  frow1 <= '0;
      col2 <= '0;  row2 <= '0;  px2 <= '0;  fg2 <= '0;  bg2 <= '0;
    end else begin
      act1 <= act0;  hs1 <= hs0;  vs1 <= vs0;
      col1 <= col0;  row1 <= row0;  px1 <= px0;  frow1 <= frow0;
      act2 <= act1;  hs2 <= hs1;  vs2 <= vs1;
      col2 <= col1;  row2 <= row1;  px2 <= px1;
      fg2  <= text_q[11:8];
      bg2  <= text_q[15:12];
    end
  end

  // S3: pixel select; the cursor inverts which colour the glyph bit picks.
  logic       glyph_bit, cur_hit;
  logic [3:0] pal_idx;

  always_comb begin
    glyph_bit = font_q[3'd7 - px2];
    cur_hit   = ctrl[0] && (!ctrl[1] || blink_phase) &&
                (col2 == cur_col) && (row2 == cur_row);
    pal_idx   = (glyph_bit ^ cur_hit) ? fg2 : bg2;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rgb_o   <= '0;
      de_o    <= 1'b0;
      hsync_o <= ~SYNC_ON;
      vsync_o <= ~SYNC_ON;
    end else begin
      rgb_o   <= act2 ? palette[pal_idx] : 8'h00;
      de_o    <= act2;
      hsync_o <= hs2;
      vsync_o <= vs2;
    end
  end

endmodule

// File: tb/tb_vga_text_engine.sv
// Directed bench for vga_text_engine on a reduced 64x32 raster (80x38 total,
// 8x2 cells) so several frames fit in a short run.
module tb_vga_text_engine;

  // Frame = 80 * 38 = 3040 cycles; pixel (x,y) of frame k is visible at
  // cycle 3040*k + 80*y + x + 3 counted from reset release.
  localparam int FRAME = 3040;

  logic clk = 1'b0;
  logic rstn;
  logic [7:0] rgb;
  logic hs, vs, de;
  int cyc;
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] d;

  always #5 clk = ~clk;

  vga_text_engine_if #(.C_AXI_ADDR_WIDTH(13), .C_AXI_DATA_WIDTH(32)) bus ();

  vga_text_engine #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b0), .FONT_H(16), .BLINK_FRAMES(2),
    .C_AXI_ADDR_WIDTH(13), .C_AXI_DATA_WIDTH(32)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .axil(bus),
    .rgb_o(rgb), .hsync_o(hs), .vsync_o(vs), .de_o(de)
  );

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    int guard = 0;
    while (cyc < t && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != t) chk("sched", cyc, t);
  endtask

  task automatic axi_write(input logic [12:0] a, input logic [31:0] wd, input logic [3:0] s);
    bus.axil_waddr_i  = a;
    bus.axil_wdata_i  = wd;
    bus.axil_wstrb_i  = s;
    bus.axil_wready_i = 1'b1;
    @(negedge clk);
    bus.axil_wready_i = 1'b0;
  endtask

  task automatic axi_read(input logic [12:0] a, output logic [31:0] rd);
    bus.axil_raddr_i = a;
    bus.axil_rreq_i  = 1'b1;
    @(negedge clk);
    bus.axil_rreq_i  = 1'b0;
    rd = bus.axil_rdata_o;
  endtask

  task automatic push_cell(input logic [7:0] glyph, input logic [7:0] fgc, input logic [7:0] bgc);
    for (int i = 0; i < 8; i++) exp_q.push_back(glyph[7-i] ? fgc : bgc);
  endtask

  task automatic check_run(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      wait_until(base + i);
      chk("pix", rgb, exp_q.pop_front());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    bus.axil_wdata_i = '0;  bus.axil_wstrb_i = '0;  bus.axil_waddr_i = '0;
    bus.axil_wready_i = 1'b0;  bus.axil_rreq_i = 1'b0;  bus.axil_raddr_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rgb", rgb, 8'h00);
    chk("rst_de", de, 1'b0);
    chk("rst_hs", hs, 1'b1);
    chk("rst_vs", vs, 1'b1);
    chk("rst_rdata", bus.axil_rdata_o, 32'h0);
    rstn = 1'b1;

    // Clean text/palette, then the scene: 'A' in cell 0, 'C' in last cell
    for (int i = 0; i < 16; i++) axi_write(13'h1000 + 13'(i), 32'h0, 4'hF);
    for (int i = 0; i < 16; i++) axi_write(13'h1F10 + 13'(i), 32'h0, 4'h1);
    axi_write(13'h1F1F, 32'hFF,   4'h1);
    axi_write(13'h1F12, 32'hE0,   4'h1);
    axi_write(13'h0410, 32'h18,   4'h1);
    axi_write(13'h0430, 32'h3C,   4'h1);
    axi_write(13'h1000, 32'h0F41, 4'h3);
    axi_write(13'h100F, 32'h2F43, 4'h3);

    // de / hsync / vsync edges in frame 0
    wait_until(66);   chk("de_last_active", de, 1'b1);
    wait_until(67);   chk("de_fp", de, 1'b0);
    wait_until(70);   chk("hs_before", hs, 1'b1);
    wait_until(71);   chk("hs_start", hs, 1'b0);
    wait_until(78);   chk("hs_end", hs, 1'b0);
    wait_until(79);   chk("hs_after", hs, 1'b1);
    wait_until(151);  chk("hs_line1_start", hs, 1'b0);
    wait_until(159);  chk("hs_line1_after", hs, 1'b1);
    wait_until(2722); chk("vs_before", vs, 1'b1);
    wait_until(2723); chk("vs_start", vs, 1'b0);
    wait_until(2882); chk("vs_end", vs, 1'b0);
    wait_until(2883); chk("vs_after", vs, 1'b1);

    // Frame 1 line 0: glyph row 0x18 in white on black, rest black
    push_cell(8'h18, 8'hFF, 8'h00);
    for (int c = 1; c < 8; c++) push_cell(8'h00, 8'h00, 8'h00);
    check_run(FRAME + 3, 64);

    // Frame 1 line 16, last cell: glyph 0x3C white on red
    push_cell(8'h3C, 8'hFF, 8'hE0);
    check_run(FRAME + 16 * 80 + 56 + 3, 8);

    // Read port
    axi_read(13'h1000, d);  chk("rd_text", d, 32'h0F41);
    @(negedge clk);         chk("rd_hold", bus.axil_rdata_o, 32'h0F41);
    axi_read(13'h0410, d);  chk("rd_font", d, 32'h18);
    axi_read(13'h1F1F, d);  chk("rd_pal", d, 32'hFF);
    axi_read(13'h1A00, d);  chk("rd_unmapped", d, 32'h0);
    axi_write(13'h1A00, 32'h1234, 4'hF);
    axi_write(13'h1010, 32'h5678, 4'hF);
    axi_read(13'h1A00, d);  chk("rd_unmapped_wr", d, 32'h0);
    axi_read(13'h1000, d);  chk("rd_text_intact", d, 32'h0F41);
    axi_write(13'h1001, 32'hABCD, 4'h1);
    axi_read(13'h1001, d);  chk("rd_strobe", d, 32'h00CD);
    bus.axil_waddr_i = 13'h1F1E;  bus.axil_wdata_i = 32'h5A;  bus.axil_wstrb_i = 4'h1;
    bus.axil_raddr_i = 13'h1F1E;  bus.axil_wready_i = 1'b1;   bus.axil_rreq_i = 1'b1;
    @(negedge clk);
    bus.axil_wready_i = 1'b0;  bus.axil_rreq_i = 1'b0;
    chk("rd_wr_same", bus.axil_rdata_o, 32'h0);
    axi_read(13'h1F1E, d);  chk("rd_after_wr", d, 32'h5A);

    wait_until(FRAME + 34 * 80 + 3); chk("vs_frame1", vs, 1'b0);

    // Steady cursor on cell 0: colours swapped for the whole cell
    axi_write(13'h1F02, 32'h1, 4'h1);
    push_cell(8'h18, 8'h00, 8'hFF);
    exp_q.push_back(8'h00);
    check_run(2 * FRAME + 3, 9);

    // Blinking cursor: visible in frames 3 and 6, hidden in 4 and 5
    axi_write(13'h1F02, 32'h3, 4'h1);
    wait_until(3 * FRAME + 3); chk("blink_f3_bg", rgb, 8'hFF);
    wait_until(3 * FRAME + 6); chk("blink_f3_fg", rgb, 8'h00);
    wait_until(4 * FRAME + 3); chk("blink_f4_bg", rgb, 8'h00);
    wait_until(4 * FRAME + 6); chk("blink_f4_fg", rgb, 8'hFF);
    wait_until(5 * FRAME + 3); chk("blink_f5_bg", rgb, 8'h00);
    wait_until(6 * FRAME + 3); chk("blink_f6_bg", rgb, 8'hFF);
    wait_until(6 * FRAME + 6); chk("blink_f6_fg", rgb, 8'h00);

    // Font overwrite mid-frame shows on the next frame
    axi_write(13'h1F02, 32'h0,  4'h1);
    axi_write(13'h0410, 32'hFF, 4'h1);
    axi_write(13'h1F00, 32'h5,  4'h1);
    push_cell(8'hFF, 8'hFF, 8'h00);
    exp_q.push_back(8'h00);
    check_run(7 * FRAME + 3, 9);

    // Asynchronous reset in the middle of an active pixel
    wait_until(8 * FRAME + 2 + 3); chk("pre_rst_pix", rgb, 8'hFF);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_rgb", rgb, 8'h00);
    chk("mid_rst_de", de, 1'b0);
    chk("mid_rst_hs", hs, 1'b1);
    chk("mid_rst_vs", vs, 1'b1);
    chk("mid_rst_rdata", bus.axil_rdata_o, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    wait_until(3);  chk("restart_pix0", rgb, 8'hFF);
    chk("restart_de", de, 1'b1);
    wait_until(11); chk("restart_pix8", rgb, 8'h00);
    axi_read(13'h1F00, d);  chk("rst_cur_col", d, 32'h0);
    axi_read(13'h1F02, d);  chk("rst_ctrl", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
